// File: rtl/calc_pkg.sv
// Shared encodings for the calculator core and the display decoder.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_DONE = 3'd2
    } state_t;

endpackage

// File: rtl/calc_edge_det.sv
// Registered rising-edge detector; history resets high so a held input gives no event.
module calc_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic cur;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur  <= 1'b1;
            prev <= 1'b1;
        end else begin
            cur  <= sig;
            prev <= cur;
        end
    end

    assign rise = cur & ~prev;

endmodule

// File: rtl/calc_seq_alu.sv
// Multi-cycle calculator core: ADD/SUB in one step, shift-add MUL and restoring DIV.
module calc_seq_alu
    import calc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 MAX10_CLK1_50,
    input  logic                 reset,
    input  logic                 op_next,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [1:0]           op_sel,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [WIDTH-1:0]     remainder,
    output logic                 carry,
    output logic                 div_by_zero,
    output logic [2:0]           cs
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t               state;
    state_t               state_nx;
    logic                 op_ev;
    logic                 start_ev;
    logic                 launch;
    logic                 short_op;
    logic                 exec_last;
    op_t                  op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   work;
    logic [2*WIDTH-1:0]   work_step;
    logic [WIDTH:0]       add_sum;
    logic [WIDTH-1:0]     sub_diff;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_trial;

    calc_edge_det u_op_edge (
        .clk   (MAX10_CLK1_50),
        .reset (reset),
        .sig   (op_next),
        .rise  (op_ev)
    );

    calc_edge_det u_start_edge (
        .clk   (MAX10_CLK1_50),
        .reset (reset),
        .sig   (start),
        .rise  (start_ev)
    );

    assign launch    = start_ev && (state != ST_EXEC);
    assign short_op  = (op_q == OP_ADD) || (op_q == OP_SUB) || ((op_q == OP_DIV) && (b_q == '0));
    assign exec_last = (state == ST_EXEC) && (short_op || (cnt == CNT_W'(WIDTH - 1)));

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: state_nx = start_ev ? ST_EXEC : ST_IDLE;
            ST_EXEC:          if (exec_last) state_nx = ST_DONE;
            default:          state_nx = ST_IDLE;
        endcase
    end

    // work holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        add_sum   = {1'b0, a_q} + {1'b0, b_q};
        sub_diff  = a_q - b_q;
        mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, a_q} : '0);
        div_trial = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]} - {1'b0, b_q};
        work_step = work;
        if (op_q == OP_MUL) begin
            work_step = {mul_sum, work[WIDTH-1:1]};
        end else if (op_q == OP_DIV) begin
            if (!div_trial[WIDTH]) work_step = {div_trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
            else                   work_step = {work[2*WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            op_sel      <= '0;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            cnt         <= '0;
            work        <= '0;
            result      <= '0;
            remainder   <= '0;
            carry       <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            if (op_ev && (state != ST_EXEC)) op_sel <= op_sel + 2'd1;

            if (launch) begin
                a_q  <= a;
                b_q  <= b;
                op_q <= op_t'(op_sel);
                cnt  <= '0;
                work <= (op_sel == OP_DIV) ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
            end else if (state == ST_EXEC) begin
                work <= work_step;
                cnt  <= cnt + CNT_W'(1);
            end

            if (exec_last) begin
                remainder   <= '0;
                carry       <= 1'b0;
                div_by_zero <= 1'b0;
                case (op_q)
                    OP_ADD: begin
                        result <= {{(WIDTH-1){1'b0}}, add_sum};
                        carry  <= add_sum[WIDTH];
                    end
                    OP_SUB: begin
                        result <= {{WIDTH{1'b0}}, sub_diff};
                        carry  <= (a_q < b_q);
                    end
                    OP_MUL: result <= work_step;
                    default: begin
                        if (b_q == '0) begin
                            result      <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                            remainder   <= a_q;
                            div_by_zero <= 1'b1;
                        end else begin
                            result    <= {{WIDTH{1'b0}}, work_step[WIDTH-1:0]};
                            remainder <= work_step[2*WIDTH-1:WIDTH];
                        end
                    end
                endcase
            end
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign cs   = state;

endmodule

// File: tb/tb_calc_seq_alu.sv
// Bench for calc_seq_alu: spec vectors, random ops vs. arithmetic model, corner sequences.
module tb_calc_seq_alu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, op_next, start;
    logic [3:0] a, b;
    logic [1:0] op_sel;
    logic       busy, done, carry, dbz;
    logic [7:0] result;
    logic [3:0] remainder;
    logic [2:0] cs;

    logic        op_next8, start8;
    logic [7:0]  a8, b8;
    logic [1:0]  op_sel8;
    logic        busy8, done8, carry8, dbz8;
    logic [15:0] result8;
    logic [7:0]  remainder8;
    logic [2:0]  cs8;

    calc_seq_alu #(.WIDTH(4)) dut (
        .MAX10_CLK1_50 (clk), .reset (reset), .op_next (op_next), .start (start),
        .a (a), .b (b), .op_sel (op_sel), .busy (busy), .done (done),
        .result (result), .remainder (remainder), .carry (carry),
        .div_by_zero (dbz), .cs (cs)
    );

    calc_seq_alu #(.WIDTH(8)) dut8 (
        .MAX10_CLK1_50 (clk), .reset (reset), .op_next (op_next8), .start (start8),
        .a (a8), .b (b8), .op_sel (op_sel8), .busy (busy8), .done (done8),
        .result (result8), .remainder (remainder8), .carry (carry8),
        .div_by_zero (dbz8), .cs (cs8)
    );

    int nvec = 0;
    int nerr = 0;
    int model_op = 0;

    typedef struct {
        int op; int a; int b; int res; int rem; int cy; int dz; int lat;
    } vec_t;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model(input int op, input int x, input int y,
                                  output int res, output int rem, output int cy,
                                  output int dz, output int lat);
        res = 0; rem = 0; cy = 0; dz = 0; lat = 2;
        case (op)
            0: begin res = x + y; cy = (x + y > 15) ? 1 : 0; end
            1: begin res = (x - y + 16) % 16; cy = (x < y) ? 1 : 0; end
            2: begin res = x * y; lat = 5; end
            default: begin
                if (y == 0) begin res = 15; rem = x; dz = 1; end
                else begin res = x / y; rem = x % y; lat = 5; end
            end
        endcase
    endfunction

    task automatic press_op;
        op_next = 1'b1; step;
        op_next = 1'b0; step; step;
        model_op = (model_op + 1) % 4;
        chk("op_sel", int'(op_sel), model_op);
    endtask

    task automatic set_op(input int target);
        while (model_op != target) press_op;
    endtask

    task automatic run_op(input string tag, input int x, input int y, input int res,
                          input int rem, input int cy, input int dz, input int lat);
        int c;
        a = x[3:0]; b = y[3:0]; start = 1'b1;
        step;
        c = 0;
        while (!done && c < 40) begin
            step;
            c++;
            if (c == 1) begin a = 4'($urandom); b = 4'($urandom); end
        end
        chk({tag, " latency"}, c, lat);
        chk({tag, " result"}, int'(result), res);
        chk({tag, " remainder"}, int'(remainder), rem);
        chk({tag, " carry"}, int'(carry), cy);
        chk({tag, " div_by_zero"}, int'(dbz), dz);
        chk({tag, " busy_in_done"}, int'(busy), 1);
        start = 1'b0;
        step;
        chk({tag, " done_one_cycle"}, int'(done), 0);
        chk({tag, " idle_after"}, int'(cs), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[9];
        int res, rem, cy, dz, lat, op, x, y, c, ndone;

        tbl[0] = '{0, 7, 6, 13, 0, 0, 0, 2};
        tbl[1] = '{0, 15, 1, 16, 0, 1, 0, 2};
        tbl[2] = '{1, 4, 6, 14, 0, 1, 0, 2};
        tbl[3] = '{2, 7, 6, 42, 0, 0, 0, 5};
        tbl[4] = '{2, 15, 15, 225, 0, 0, 0, 5};
        tbl[5] = '{3, 6, 4, 1, 2, 0, 0, 5};
        tbl[6] = '{3, 6, 0, 15, 6, 0, 1, 2};
        tbl[7] = '{3, 9, 3, 3, 0, 0, 0, 5};
        tbl[8] = '{1, 9, 9, 0, 0, 0, 0, 2};

        reset = 1'b1; op_next = 1'b0; start = 1'b0; a = '0; b = '0;
        op_next8 = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) step;
        reset = 1'b0;
        step;
        chk("rst op_sel", int'(op_sel), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst result", int'(result), 0);
        chk("rst remainder", int'(remainder), 0);
        chk("rst carry", int'(carry), 0);
        chk("rst div_by_zero", int'(dbz), 0);
        chk("rst cs", int'(cs), 0);

        repeat (4) press_op;

        foreach (tbl[i]) begin
            set_op(tbl[i].op);
            run_op("tbl", tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].rem,
                   tbl[i].cy, tbl[i].dz, tbl[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 3);
            x  = $urandom_range(0, 15);
            y  = (i % 10 == 0) ? 0 : $urandom_range(0, 15);
            model(op, x, y, res, rem, cy, dz, lat);
            set_op(op);
            run_op("rnd", x, y, res, rem, cy, dz, lat);
        end

        // op_next and start while a MUL is running must both be ignored
        set_op(2);
        a = 4'd5; b = 4'd3; start = 1'b1;
        ndone = 0;
        step; step;
        start = 1'b0; op_next = 1'b1;
        step;
        op_next = 1'b0; start = 1'b1;
        step;
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step;
            if (done) ndone++;
        end
        chk("busy single_done", ndone, 1);
        chk("busy result", int'(result), 15);
        chk("busy op_sel", int'(op_sel), 2);

        // Simultaneous events: SUB runs with the old op, op_sel still advances
        set_op(1);
        a = 4'd9; b = 4'd2; start = 1'b1; op_next = 1'b1;
        step;
        op_next = 1'b0;
        c = 0;
        while (!done && c < 40) begin step; c++; end
        model_op = 2;
        chk("simul latency", c, 2);
        chk("simul result", int'(result), 7);
        chk("simul carry", int'(carry), 0);
        chk("simul op_sel", int'(op_sel), model_op);
        start = 1'b0;
        step;

        // Reset in the middle of a MUL
        set_op(2);
        a = 4'd7; b = 4'd6; start = 1'b1;
        repeat (4) step;
        reset = 1'b1;
        step;
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst result", int'(result), 0);
        chk("midrst op_sel", int'(op_sel), 0);
        chk("midrst cs", int'(cs), 0);
        reset = 1'b0;
        model_op = 0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            step;
            if (done) ndone++;
        end
        chk("midrst no_done", ndone, 0);
        chk("midrst held_start_cs", int'(cs), 0);
        start = 1'b0;
        step;

        // WIDTH=8 instance: MUL latency and products
        repeat (2) begin
            op_next8 = 1'b1; step;
            op_next8 = 1'b0; step; step;
        end
        chk("w8 op_sel", int'(op_sel8), 2);
        for (int i = 0; i < 4; i++) begin
            x = (i == 0) ? 200 : $urandom_range(0, 255);
            y = (i == 0) ? 3 : $urandom_range(0, 255);
            a8 = x[7:0]; b8 = y[7:0]; start8 = 1'b1;
            step;
            c = 0;
            while (!done8 && c < 40) begin step; c++; end
            chk("w8 latency", c, 9);
            chk("w8 result", int'(result8), x * y);
            start8 = 1'b0;
            step;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
